// File: rtl/alu_issue_arbiter_pkg.sv
// alu_issue_arbiter_pkg: ALU func codes, tag type and ALU default result shared by the arbiter slice
package alu_issue_arbiter_pkg;
    localparam int TAG_W = 6;
    localparam logic [63:0] ALU_DEFAULT = 64'hdeadbeefbaadbeef;
    typedef logic [TAG_W-1:0] tag_t;
    typedef enum logic [4:0] {
        ALU_ADDQ   = 5'h00,
        ALU_SUBQ   = 5'h01,
        ALU_AND    = 5'h02,
        ALU_BIC    = 5'h03,
        ALU_BIS    = 5'h04,
        ALU_ORNOT  = 5'h05,
        ALU_XOR    = 5'h06,
        ALU_EQV    = 5'h07,
        ALU_SRL    = 5'h08,
        ALU_SLL    = 5'h09,
        ALU_SRA    = 5'h0a,
        ALU_MULQ   = 5'h0b,
        ALU_CMPULT = 5'h0c,
        ALU_CMPEQ  = 5'h0d,
        ALU_CMPULE = 5'h0e,
        ALU_CMPLT  = 5'h0f,
        ALU_CMPLE  = 5'h10
    } alu_func_e;
endpackage

// File: rtl/alu.sv
// alu: 64-bit combinational ALU; unknown func codes yield ALU_DEFAULT
module alu
    import alu_issue_arbiter_pkg::*;
(
    input  logic [63:0] opa,
    input  logic [63:0] opb,
    input  logic [4:0]  func,
    output logic [63:0] result
);
    always_comb begin
        case (func)
            ALU_ADDQ:   result = opa + opb;
            ALU_SUBQ:   result = opa - opb;
            ALU_AND:    result = opa & opb;
            ALU_BIC:    result = opa & ~opb;
            ALU_BIS:    result = opa | opb;
            ALU_ORNOT:  result = opa | ~opb;
            ALU_XOR:    result = opa ^ opb;
            ALU_EQV:    result = ~(opa ^ opb);
            ALU_SRL:    result = opa >> opb[5:0];
            ALU_SLL:    result = opa << opb[5:0];
            ALU_SRA:    result = $signed(opa) >>> opb[5:0];
            ALU_MULQ:   result = opa * opb;
            ALU_CMPULT: result = 64'(opa < opb);
            ALU_CMPEQ:  result = 64'(opa == opb);
            ALU_CMPULE: result = 64'(opa <= opb);
            ALU_CMPLT:  result = 64'($signed(opa) < $signed(opb));
            ALU_CMPLE:  result = 64'($signed(opa) <= $signed(opb));
            default:    result = ALU_DEFAULT;
        endcase
    end
endmodule

// File: rtl/alu_issue_arbiter_rr_picker.sv
// rr_picker: one-hot grant searching upward from ptr with wrap; ALU_ARB_FIXED_PRIO_EN makes lowest index win
module rr_picker #(
    parameter int N_REQ = 4,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx
);
    int j;
    always_comb begin
        grant = '0;
        idx = '0;
        j = 0;
        // walk the search order backwards so the earliest hit is the one left standing
        for (int o = N_REQ - 1; o >= 0; o--) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            j = o;
`else
            j = (int'(ptr) + o) % N_REQ;
`endif
            if (en && req[j]) begin
                grant = '0;
                grant[j] = 1'b1;
                idx = IW'(j);
            end
        end
    end
endmodule

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: shares one ALU among N_REQ requesters into a registered CDB stage (ALU_ARB_FIXED_PRIO_EN: fixed priority)
module alu_issue_arbiter #(
    parameter int N_REQ = 4,
    parameter int TAG_W = 6
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ-1:0][63:0]        req_opa,
    input  logic [N_REQ-1:0][63:0]        req_opb,
    input  logic [N_REQ-1:0][4:0]         req_func,
    input  logic [N_REQ-1:0][TAG_W-1:0]   req_tag,
    output logic [N_REQ-1:0]              req_grant,
    output logic                          out_valid,
    output logic [63:0]                   out_result,
    output logic [TAG_W-1:0]              out_tag,
    input  logic                          out_ready,
    output logic [31:0]                   issue_count
);
    import alu_issue_arbiter_pkg::*;
    localparam int IW = $clog2(N_REQ);
    logic [IW-1:0] idx;
    logic [IW-1:0] rr_ptr;
    logic [63:0] alu_res;
    logic en;
    assign en = (!out_valid || out_ready) && !reset;
    rr_picker #(.N_REQ(N_REQ)) u_pick (
        .req(req_valid),
        .ptr(rr_ptr),
        .en(en),
        .grant(req_grant),
        .idx(idx)
    );
    alu u_alu (
        .opa(req_opa[idx]),
        .opb(req_opb[idx]),
        .func(req_func[idx]),
        .result(alu_res)
    );
`ifdef ALU_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clock) begin
        if (reset)
            rr_ptr <= '0;
        else if (|req_grant)
            rr_ptr <= (int'(idx) == N_REQ - 1) ? '0 : idx + IW'(1);
    end
`endif
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_result <= '0;
            out_tag <= '0;
            issue_count <= '0;
        end else if (|req_grant) begin
            out_valid <= 1'b1;
            out_result <= alu_res;
            out_tag <= req_tag[idx];
            if (~&issue_count)
                issue_count <= issue_count + 32'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: directed checks of grant order, latency, backpressure, wrap, default func and reset
module tb_alu_issue_arbiter;
    logic             clock;
    logic             reset;
    logic [3:0]       req_valid;
    logic [3:0][63:0] req_opa;
    logic [3:0][63:0] req_opb;
    logic [3:0][4:0]  req_func;
    logic [3:0][5:0]  req_tag;
    logic [3:0]       req_grant;
    logic             out_valid;
    logic [63:0]      out_result;
    logic [5:0]       out_tag;
    logic             out_ready;
    logic [31:0]      issue_count;
    int checks = 0;
    int errors = 0;

    alu_issue_arbiter #(.N_REQ(4), .TAG_W(6)) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_opa(req_opa),
        .req_opb(req_opb),
        .req_func(req_func),
        .req_tag(req_tag),
        .req_grant(req_grant),
        .out_valid(out_valid),
        .out_result(out_result),
        .out_tag(out_tag),
        .out_ready(out_ready),
        .issue_count(issue_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", nm, o, e);
        end
    endtask

    task automatic cyc(input string nm, input logic [3:0] g, input logic v, input logic [63:0] r, input logic [5:0] t);
        #1;
        chk({nm, "_grant"}, 64'(req_grant), 64'(g));
        @(posedge clock);
        #1;
        chk({nm, "_valid"}, 64'(out_valid), 64'(v));
        chk({nm, "_result"}, out_result, r);
        chk({nm, "_tag"}, 64'(out_tag), 64'(t));
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            req_opa[i] = 64'(i);
            req_opb[i] = 64'(10 * i);
            req_func[i] = 5'h00;
            req_tag[i] = 6'(8 + i);
        end
        cyc("rst0", 4'b0000, 1'b0, 64'd0, 6'd0);
        cyc("rst1", 4'b0000, 1'b0, 64'd0, 6'd0);
        chk("rst_count", 64'(issue_count), 64'd0);
        reset = 1'b0;
        cyc("rr0", 4'b0001, 1'b1, 64'd0, 6'd8);
        chk("rr0_count", 64'(issue_count), 64'd1);
        cyc("rr1", 4'b0010, 1'b1, 64'd11, 6'd9);
        cyc("rr2", 4'b0100, 1'b1, 64'd22, 6'd10);
        cyc("rr3", 4'b1000, 1'b1, 64'd33, 6'd11);
        cyc("rr4", 4'b0001, 1'b1, 64'd0, 6'd8);
        chk("rr_count", 64'(issue_count), 64'd5);
        req_valid = 4'b0000;
        cyc("drain", 4'b0000, 1'b0, 64'd0, 6'd8);
        req_valid = 4'b0100;
        req_func[2] = 5'h01;
        req_opa[2] = 64'd5;
        req_opb[2] = 64'd7;
        req_tag[2] = 6'd42;
        out_ready = 1'b0;
        cyc("bp0", 4'b0100, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 6'd42);
        cyc("bp1", 4'b0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 6'd42);
        cyc("bp2", 4'b0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 6'd42);
        out_ready = 1'b1;
        cyc("bp_release", 4'b0100, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 6'd42);
        chk("bp_count", 64'(issue_count), 64'd7);
        req_valid = 4'b0010;
        cyc("wrap", 4'b0010, 1'b1, 64'd11, 6'd9);
        req_valid = 4'b1001;
        cyc("skip", 4'b1000, 1'b1, 64'd33, 6'd11);
        req_valid = 4'b0001;
        req_func[0] = 5'h1F;
        req_opa[0] = 64'd1;
        req_opb[0] = 64'd2;
        cyc("badfunc", 4'b0001, 1'b1, 64'hdeadbeefbaadbeef, 6'd8);
        chk("pre_reset_count", 64'(issue_count), 64'd10);
        req_func[0] = 5'h00;
        req_valid = 4'b1111;
        reset = 1'b1;
        cyc("midrst", 4'b0000, 1'b0, 64'd0, 6'd0);
        chk("midrst_count", 64'(issue_count), 64'd0);
        reset = 1'b0;
        cyc("post_rst", 4'b0001, 1'b1, 64'd3, 6'd8);
        req_valid = 4'b1010;
`ifdef ALU_ARB_FIXED_PRIO_EN
        cyc("prio0", 4'b0010, 1'b1, 64'd11, 6'd9);
        cyc("prio1", 4'b0010, 1'b1, 64'd11, 6'd9);
        cyc("prio2", 4'b0010, 1'b1, 64'd11, 6'd9);
`else
        cyc("prio0", 4'b0010, 1'b1, 64'd11, 6'd9);
        cyc("prio1", 4'b1000, 1'b1, 64'd33, 6'd11);
        cyc("prio2", 4'b0010, 1'b1, 64'd11, 6'd9);
`endif
        chk("final_count", 64'(issue_count), 64'd4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares one combinational `alu` instance among N_REQ requesters (reservation-station entries).
- Selects one requester per cycle, round-robin by default, and drives its operands and func into the ALU.
- Registers the ALU result, with its destination tag, into a single-entry output stage toward the CDB.
- The output stage has valid/ready backpressure.

Parameters:
- N_REQ, 4, number of requesters; must be 2 to 16.
- TAG_W, 6, width of the destination tag carried with each op.

Ports:
- clock  in  1  system clock; all state updates on the posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  requester i holds an op ready to issue.
- req_opa  in  N_REQ x 64  operand A per requester.
- req_opb  in  N_REQ x 64  operand B per requester.
- req_func  in  N_REQ x 5  ALU func code per requester.
- req_tag  in  N_REQ x TAG_W  destination tag per requester.
- req_grant  out  N_REQ  one-hot; requester i's op is accepted this cycle.
- out_valid  out  1  output stage holds a result.
- out_result  out  64  registered ALU result.
- out_tag  out  TAG_W  tag of out_result.
- out_ready  in  1  consumer takes out_result this cycle.
- issue_count  out  32  number of accepted ops; saturates at 32'hFFFF_FFFF.

Behaviour:
- Reset values, while reset is high: out_valid=0, out_result=0, out_tag=0, rr_ptr=0, issue_count=0.
- During reset, req_grant is forced to 0.
- A reset mid-operation discards any held result; no grant is issued in a reset cycle.
- accept = !out_valid || out_ready. This allows full throughput of one op per cycle under continuous out_ready.
- Grant is combinational, in the same cycle as the request:
  - if accept and |req_valid, exactly one bit of req_grant is set;
  - otherwise req_grant=0.
- Requester obligations: hold req_valid and payload stable until granted. Dropping req_valid before grant is legal (withdrawal).
- Round-robin:
  - search req_valid starting at index rr_ptr, ascending, wrapping from N_REQ-1 to 0;
  - the first set bit k is granted;
  - next cycle rr_ptr = (k+1) mod N_REQ;
  - rr_ptr is unchanged when no grant is issued.
- ALU inputs are muxed from the granted index. When there is no grant, index 0 is muxed (don't-care).
- Latency is 1 cycle. On a grant at cycle t: out_valid=1, out_result=alu(opa,opb,func) and out_tag=req_tag[k] at t+1.
- Output stage:
  - grant and out_ready in the same cycle: new result replaces the old one; out_valid stays 1.
  - out_ready with no grant: out_valid goes to 0, and out_result/out_tag hold their values.
  - out_valid=1 and out_ready=0: no grant; out_result and out_tag are held stable.
- An unrecognised func passes through the ALU default, 64'hdeadbeefbaadbeef. This is not an error.
- issue_count increments by 1 per grant and sticks at all-ones.
- The block introduces no combinational path from out_ready to out_result. The path out_ready -> req_grant is permitted.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest set index of req_valid wins; rr_ptr is removed and starvation is possible.
- Undefined (default): round-robin as above.
- All other behaviour is identical in both modes.

Decomposition:
- Shared package: ALU func enum (ALU_ADDQ through ALU_CMPLE), a TAG_W-sized tag typedef, and the 64'hdeadbeefbaadbeef default constant.
- One natural sub-module: rr_picker. It takes req vector, rr_ptr and enable, and produces a one-hot grant and the granted index.
- rr_picker is parameterised by N_REQ and contains the ALU_ARB_FIXED_PRIO_EN switch.
- alu_issue_arbiter instantiates rr_picker and alu, and owns the output register, rr_ptr and issue_count.

Test Plan:
- Reset held 2 cycles with req_valid=4'b1111 -> req_grant=0, out_valid=0, issue_count=0. First cycle after reset: grant=4'b0001.
- All four requesting continuously, out_ready=1, ADDQ operands (i, 10·i) -> grants 0,1,2,3,0 on consecutive cycles. out_result 0,11,22,33,0 one cycle later, each with its tag.
- Backpressure:
  - req_valid=4'b0100, SUBQ 5-7, out_ready=0 for 3 cycles -> one grant, then none.
  - out_result=64'hFFFF_FFFF_FFFF_FFFE held stable.
  - out_ready=1 -> next grant in that same cycle.
- Wrap and skip: rr_ptr=3, req_valid=4'b0010 -> grant 4'b0010, rr_ptr becomes 2. Then req_valid=4'b1001 -> grant 4'b1000.
- func=5'h1F (unused), opa=1, opb=2 -> out_result=64'hdeadbeefbaadbeef, out_valid=1.
- Mid-stream reset while out_valid=1 -> next cycle out_valid=0, rr_ptr=0, issue_count=0.
- With ALU_ARB_FIXED_PRIO_EN defined, req_valid=4'b1010 for 3 cycles -> grant 4'b0010 every cycle.
